// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel encodings, default widths and arbiter state type
// for the npc memory path.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb_sel.sv
// Combinational 2-way grant picker for the read arbiter.
// AXI_RD_ARB_RR_EN selects round-robin tie-break; otherwise master 1 wins ties.
module axi_rd_arb_sel
    import axi_pkg::*;
(
    input  logic [1:0] arvalid,
`ifdef AXI_RD_ARB_RR_EN
    input  logic       last_gnt,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = arvalid;
        if (arvalid == 2'b11) begin
`ifdef AXI_RD_ARB_RR_EN
            // tie goes to whichever master was not served last
            grant = last_gnt ? 2'b01 : 2'b10;
`else
            grant = 2'b10;
`endif
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (ICache=0, DCache=1) to one-slave AXI4 read arbiter, one burst
// in flight. Optional round-robin tie-break under AXI_RD_ARB_RR_EN.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    input  logic [1:0]        m0_arburst,
    input  logic [LEN_W-1:0]  m0_arlen,
    input  logic [2:0]        m0_arsize,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic              m0_rready,

    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    input  logic [1:0]        m1_arburst,
    input  logic [LEN_W-1:0]  m1_arlen,
    input  logic [2:0]        m1_arsize,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    input  logic              m1_rready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic [1:0]        s_arburst,
    output logic [LEN_W-1:0]  s_arlen,
    output logic [2:0]        s_arsize,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              s_rready
);

    arb_state_e state, state_nxt;
    logic       gnt;
    logic [LEN_W:0] beat_cnt;

    logic [1:0]             arvalid;
    logic [1:0]             grant;
    logic [1:0][ADDR_W-1:0] araddr;
    logic [1:0][1:0]        arburst;
    logic [1:0][LEN_W-1:0]  arlen;
    logic [1:0][2:0]        arsize;
    logic [1:0]             rready;
    logic                   sel_rready;
    logic                   ar_hs;
    logic                   r_hs;

    assign arvalid = {m1_arvalid, m0_arvalid};
    assign araddr  = {m1_araddr,  m0_araddr};
    assign arburst = {m1_arburst, m0_arburst};
    assign arlen   = {m1_arlen,   m0_arlen};
    assign arsize  = {m1_arsize,  m0_arsize};
    assign rready  = {m1_rready,  m0_rready};

    assign sel_rready = rready[gnt];
    assign ar_hs      = (state == ST_IDLE) && (grant != 2'b00) && !rst;
    assign r_hs       = (state == ST_R) && s_rvalid && sel_rready;

`ifdef AXI_RD_ARB_RR_EN
    logic last_gnt;

    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (r_hs && s_rlast)
            last_gnt <= gnt;
    end

    axi_rd_arb_sel u_sel (
        .arvalid  (arvalid),
        .last_gnt (last_gnt),
        .grant    (grant)
    );
`else
    axi_rd_arb_sel u_sel (
        .arvalid (arvalid),
        .grant   (grant)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            s_araddr  <= '0;
            s_arburst <= '0;
            s_arlen   <= '0;
            s_arsize  <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                gnt       <= grant[1];
                s_araddr  <= araddr[grant[1]];
                s_arburst <= arburst[grant[1]];
                s_arlen   <= arlen[grant[1]];
                s_arsize  <= arsize[grant[1]];
            end
            if (state == ST_AR && s_arready)
                beat_cnt <= '0;
            else if (r_hs)
                beat_cnt <= beat_cnt + (LEN_W+1)'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rlast   = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m1_rvalid  = 1'b0;
        m1_rlast   = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        unique case (state)
            ST_IDLE: begin
                m0_arready = grant[0] && !rst;
                m1_arready = grant[1] && !rst;
                if (grant != 2'b00)
                    state_nxt = ST_AR;
            end
            ST_AR: begin
                s_arvalid = 1'b1;
                if (s_arready)
                    state_nxt = ST_R;
            end
            ST_R: begin
                // R beats pass straight through to the owner, no register stage
                s_rready = sel_rready;
                if (gnt) begin
                    m1_rvalid = s_rvalid;
                    m1_rlast  = s_rlast;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rlast  = s_rlast;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                if (r_hs && s_rlast)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A beat outside R means the slave is out of step with the arbiter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (state == ST_R || !s_rvalid);
            if (r_hs) begin
                if (s_rlast)
                    assert (beat_cnt == {1'b0, s_arlen});
                else
                    assert (beat_cnt < {1'b0, s_arlen});
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: expected AR order and beats
// are queued at issue time and popped by an independent monitor.
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic          m0_arvalid, m1_arvalid;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst;
    logic [LW-1:0] m0_arlen, m1_arlen, s_arlen;
    logic [2:0]    m0_arsize, m1_arsize, s_arsize;
    logic          m0_arready, m1_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic          m0_rready, m1_rready;
    logic          s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arburst(m0_arburst),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arburst(m1_arburst),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rlast(s_rlast), .s_rready(s_rready)
    );

    typedef struct { int m; logic [AW-1:0] addr; logic [LW-1:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_r0[$];
    beat_t exp_r1[$];

    int errors = 0;
    int checks = 0;
    int last_w = 1;
    bit in_txn = 0;
    int cur_m  = 0;
    int act_gnt = 0;
    int beats0 = 0;
    int stall_left = 0;
    int rdy_mode[2];

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
        return {a ^ 32'h5A5A_0000, 32'(i) ^ 32'hC0DE_0000};
    endfunction

    function automatic logic [1:0] beat_resp(input logic [AW-1:0] a, input int i);
        return ((a[5:3] + 3'(i)) == 3'd5) ? SLVERR : OKAY;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    // Who the spec says wins when both masters request in the same IDLE cycle.
    function automatic int tie_winner();
`ifdef AXI_RD_ARB_RR_EN
        return (last_w == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    task automatic push_txn(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l);
        beat_t b;
        exp_ar.push_back('{m, a, l});
        for (int i = 0; i <= int'(l); i++) begin
            b = '{beat_data(a, i), beat_resp(a, i), (i == int'(l))};
            if (m == 0) exp_r0.push_back(b);
            else        exp_r1.push_back(b);
        end
        last_w = m;
    endtask

    task automatic do_req(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int  n   = 0;
        bit  got = 0;
        @(negedge clk);
        if (m == 0) begin
            m0_araddr = a; m0_arlen = l; m0_arburst = BURST_INCR; m0_arsize = 3'd3; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = a; m1_arlen = l; m1_arburst = BURST_INCR; m1_arsize = 3'd3; m1_arvalid = 1'b1;
        end
        while (!got && n < 500) begin
            #2;
            got = (m == 0) ? m0_arready : m1_arready;
            @(negedge clk);
            n++;
        end
        if (m == 0) m0_arvalid = 1'b0;
        else        m1_arvalid = 1'b0;
        if (!got) fail_now("arready_timeout", $sformatf("master %0d never granted", m));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_ar.size() != 0 || exp_r0.size() != 0 || exp_r1.size() != 0 || in_txn) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000)
            fail_now("idle_timeout", $sformatf("ar=%0d r0=%0d r1=%0d beats outstanding",
                     exp_ar.size(), exp_r0.size(), exp_r1.size()));
    endtask

    task automatic run_pair(input bit u0, input bit u1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                            input int d0, input int d1);
        int first;
        if (u0 && u1) begin
            first = (d0 == d1) ? tie_winner() : ((d0 < d1) ? 0 : 1);
            if (first == 0) begin push_txn(0, a0, l0); push_txn(1, a1, l1); end
            else            begin push_txn(1, a1, l1); push_txn(0, a0, l0); end
        end else if (u0) begin
            push_txn(0, a0, l0);
        end else if (u1) begin
            push_txn(1, a1, l1);
        end
        fork
            begin if (u0) begin repeat (d0) @(negedge clk); do_req(0, a0, l0); end end
            begin if (u1) begin repeat (d1) @(negedge clk); do_req(1, a1, l1); end end
        join
        wait_idle();
    endtask

    // R-ready drivers: 0 random, 1 toggling, 2 always ready
    initial begin
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        forever begin
            @(negedge clk);
            m0_rready = (rdy_mode[0] == 2) ? 1'b1 : (rdy_mode[0] == 1) ? ~m0_rready : ($urandom_range(2, 0) != 0);
            m1_rready = (rdy_mode[1] == 2) ? 1'b1 : (rdy_mode[1] == 1) ? ~m1_rready : ($urandom_range(2, 0) != 0);
        end
    end

    // Memory slave: random AR acceptance and beat gaps, data derived from address
    bit            f_ar, f_r, f_arv, f_rst;
    logic [AW-1:0] f_addr, sl_addr;
    logic [LW-1:0] f_len, sl_len;
    int            sl_idx;
    bit            sl_busy;

    initial begin
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;
        f_ar = 0; f_r = 0; f_arv = 0; f_rst = 1; sl_busy = 0; sl_idx = 0;
        forever begin
            @(negedge clk);
            if (f_rst) begin
                sl_busy = 0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0; s_arready = 1'b0;
            end else begin
                if (f_r) begin
                    if (s_rlast) sl_busy = 0;
                    else         sl_idx++;
                    s_rvalid = 1'b0;
                    s_rlast  = 1'b0;
                end
                if (f_ar) begin
                    if (sl_busy) fail_now("slave_overlap", "second AR while a burst is open");
                    sl_busy = 1; sl_addr = f_addr; sl_len = f_len; sl_idx = 0;
                end
                if (sl_busy && !s_rvalid && $urandom_range(3, 0) != 0) begin
                    s_rvalid = 1'b1;
                    s_rdata  = beat_data(sl_addr, sl_idx);
                    s_rresp  = beat_resp(sl_addr, sl_idx);
                    s_rlast  = (sl_idx == int'(sl_len));
                end
                if (stall_left > 0) begin
                    s_arready = 1'b0;
                    if (f_arv) stall_left--;
                end else begin
                    s_arready = $urandom_range(1, 0) != 0;
                end
            end
            #2;
            f_rst = rst; f_ar = s_arvalid && s_arready; f_r = s_rvalid && s_rready;
            f_arv = s_arvalid; f_addr = s_araddr; f_len = s_arlen;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake
    bit            p_mhs, p_wait, p_rlast, p_rst;
    logic [AW-1:0] p_addr, w_addr;
    logic [LW-1:0] p_len, w_len;
    logic          rv[2], rr[2], rl[2];
    logic [DW-1:0] rd[2];
    logic [1:0]    rs[2];
    bit            done_last;
    beat_t         b;
    ar_t           e;

    initial begin
        p_mhs = 0; p_wait = 0; p_rlast = 0; p_rst = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_ar.delete(); exp_r0.delete(); exp_r1.delete();
                in_txn = 0; p_mhs = 0; p_wait = 0; p_rlast = 0; p_rst = 1;
                continue;
            end
            if (p_rst) begin
                chk("post_rst_idle", {s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 0);
                p_rst = 0;
            end
            if (m0_arready || m1_arready)
                chk("arready_legal", {m0_arready & m1_arready, s_arvalid, in_txn,
                                      (m0_arready & ~m0_arvalid) | (m1_arready & ~m1_arvalid)}, 0);
            if (p_rlast && (m0_arvalid || m1_arvalid))
                chk("regrant_after_rlast", m0_arready | m1_arready, 1);
            if (p_mhs) begin
                chk("ar_latency", s_arvalid, 1);
                chk("ar_fwd_payload", {s_araddr, s_arlen}, {p_addr, p_len});
                chk("ar_burst_size", {s_arburst, s_arsize}, {BURST_INCR, 3'd3});
            end
            if (p_wait)
                chk("ar_stable", {s_arvalid, s_araddr, s_arlen}, {1'b1, w_addr, w_len});

            rv = '{m0_rvalid, m1_rvalid}; rr = '{m0_rready, m1_rready}; rl = '{m0_rlast, m1_rlast};
            rd = '{m0_rdata, m1_rdata};   rs = '{m0_rresp, m1_rresp};
            if (in_txn) begin
                chk("rready_mirror", s_rready, rr[cur_m]);
                chk("rvalid_pass", rv[cur_m], s_rvalid);
            end else begin
                chk("rready_idle", s_rready, 0);
            end
            done_last = 0;
            for (int m = 0; m < 2; m++) begin
                if (in_txn && m != cur_m)
                    chk("nongnt_zero", {rv[m], rl[m], rs[m], rd[m]}, 0);
                if (rv[m] && !(in_txn && m == cur_m)) begin
                    fail_now("stray_rvalid", $sformatf("master %0d rvalid with no burst routed to it", m));
                end else if (rv[m] && rr[m]) begin
                    if ((m == 0 && exp_r0.size() == 0) || (m == 1 && exp_r1.size() == 0)) begin
                        fail_now("extra_beat", $sformatf("master %0d got a beat beyond the burst", m));
                    end else begin
                        if (m == 0) b = exp_r0.pop_front();
                        else        b = exp_r1.pop_front();
                        chk($sformatf("r_data_m%0d", m), rd[m], b.data);
                        chk($sformatf("r_resp_m%0d", m), rs[m], b.resp);
                        chk($sformatf("r_last_m%0d", m), rl[m], b.last);
                        if (m == 0) beats0++;
                    end
                    if (rl[m]) done_last = 1;
                end
            end
            if (done_last) in_txn = 0;
            p_rlast = done_last;

            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) begin
                    fail_now("unexpected_ar", "slave AR handshake with nothing expected");
                end else begin
                    e = exp_ar.pop_front();
                    chk("ar_master", act_gnt, e.m);
                    chk("ar_slave_payload", {s_araddr, s_arlen}, {e.addr, e.len});
                    cur_m  = e.m;
                    in_txn = 1;
                end
            end

            p_mhs = 0;
            if (m0_arvalid && m0_arready) begin
                p_mhs = 1; act_gnt = 0; p_addr = m0_araddr; p_len = m0_arlen;
            end else if (m1_arvalid && m1_arready) begin
                p_mhs = 1; act_gnt = 1; p_addr = m1_araddr; p_len = m1_arlen;
            end
            p_wait = s_arvalid && !s_arready;
            w_addr = s_araddr;
            w_len  = s_arlen;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit u0, u1;
        int mode;
        m0_arvalid = 0; m1_arvalid = 0;
        m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
        m0_arburst = '0; m1_arburst = '0; m0_arsize = '0; m1_arsize = '0;
        rdy_mode[0] = 2; rdy_mode[1] = 2;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready}, 0);
        chk("reset_ar_payload", {s_araddr, s_arlen, s_arburst, s_arsize}, 0);
        @(negedge clk);
        rst = 1'b0;
        last_w = 1;

        // simultaneous requests right after reset
        run_pair(1, 1, 32'h8000_1000, 32'h8000_2000, 8'd1, 8'd2, 0, 0);
        // m0 alone, 4-beat burst
        run_pair(1, 0, 32'h8000_0000, 32'h0, 8'd3, 8'd0, 0, 0);
        // single-beat burst from m1 with m0 queued behind it
        run_pair(1, 1, 32'h8000_3000, 32'h8000_4000, 8'd2, 8'd0, 1, 0);
        // slave holds arready low for 5 cycles
        stall_left = 5;
        run_pair(0, 1, 32'h0, 32'h8000_5000, 8'd0, 8'd4, 0, 0);
        // toggling m0_rready over an 8-beat burst
        rdy_mode[0] = 1;
        run_pair(1, 0, 32'h8000_6000, 32'h0, 8'd7, 8'd0, 0, 0);
        rdy_mode[0] = 2;

        // reset in the middle of an 8-beat burst
        beats0 = 0;
        push_txn(0, 32'h8000_7000, 8'd7);
        do_req(0, 32'h8000_7000, 8'd7);
        n = 0;
        while (beats0 < 2 && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 500) fail_now("beat2_timeout", "second beat never delivered");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_w = 1;
        run_pair(0, 1, 32'h0, 32'h8000_8000, 8'd0, 8'd2, 0, 0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(2, 0);
            u0 = (mode != 1);
            u1 = (mode != 0);
            rdy_mode[0] = $urandom_range(1, 0) ? 2 : 0;
            rdy_mode[1] = $urandom_range(1, 0) ? 2 : 0;
            run_pair(u0, u1,
                     {$urandom} & 32'hFFFF_FFF8, {$urandom} & 32'hFFFF_FFF8,
                     8'($urandom_range(7, 0)), 8'($urandom_range(7, 0)),
                     $urandom_range(1, 0), $urandom_range(1, 0));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
